// File: rtl/wr_ddr_burst_ctrl_pkg.sv
// Shared types and widths for the DDR4 write-burst controller.
package wr_ddr_burst_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    localparam int APP_DATA_W = 512;
    localparam int APP_ADDR_W = 29;
    localparam int APP_MASK_W = 64;
    localparam int CNT_W      = 6;

endpackage

// File: rtl/wr_ddr_burst_ctrl.sv
// Moves BURST_LEN-beat bursts from a FWFT write FIFO into the DDR4 app write interface.
// Latency: burst starts the cycle after FIFO occupancy reaches BURST_LEN; one beat per cycle when ready.
// Backpressure: command and data channels stall independently on app_rdy / app_wdf_rdy; nothing is skipped or repeated.
module wr_ddr_burst_ctrl
    import wr_ddr_burst_ctrl_pkg::*;
#(
    parameter int BURST_LEN   = 16,
    parameter int FRAME_BEATS = 129600,
    parameter int ADDR_STEP   = 8
) (
    input  logic                  ui_clk,
    input  logic                  ui_clk_sync_rst,
    input  logic                  init_calib_complete,
    input  logic [CNT_W-1:0]      p0_wr_count,
    input  logic                  p0_wr_empty,
    input  logic [APP_DATA_W-1:0] p0_wr_dout,
    output logic                  p0_rd_en,
    input  logic                  app_rdy,
    input  logic                  app_wdf_rdy,
    output logic                  app_en,
    output logic [2:0]            app_cmd,
    output logic [APP_ADDR_W-1:0] app_addr,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    output logic [APP_DATA_W-1:0] app_wdf_data,
    output logic [APP_MASK_W-1:0] app_wdf_mask,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int BIDX_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [BIDX_W-1:0]     LAST_BEAT = BIDX_W'(FRAME_BEATS - 1);
    localparam logic [CNT_W-1:0]      BURST_CNT = CNT_W'(BURST_LEN);
    localparam logic [APP_ADDR_W-1:0] STEP      = APP_ADDR_W'(ADDR_STEP);

    state_e                  state_q;
    state_e                  state_d;
    logic [CNT_W-1:0]        cmd_cnt;
    logic [CNT_W-1:0]        dat_cnt;
    logic [BIDX_W-1:0]       beat_idx;
    logic [APP_ADDR_W-1:0]   addr_q;
    logic                    frame_done_q;
    logic                    in_burst;
    logic                    cmd_done;
    logic                    dat_done;
    logic                    cmd_acc;
    logic                    dat_acc;
    logic                    start;

    assign in_burst = (state_q != ST_IDLE);
    assign cmd_done = (cmd_cnt == BURST_CNT);
    assign dat_done = (dat_cnt == BURST_CNT);
    assign start    = (state_q == ST_IDLE) && init_calib_complete && (p0_wr_count >= BURST_CNT);

    // Reset gates the handshakes combinationally so an abandoned burst gets no extra beat.
    assign app_en       = in_burst && !cmd_done && !ui_clk_sync_rst;
    assign app_wdf_wren = in_burst && !dat_done && !p0_wr_empty && !ui_clk_sync_rst;
    assign cmd_acc      = app_en && app_rdy;
    assign dat_acc      = app_wdf_wren && app_wdf_rdy;

    assign p0_rd_en     = dat_acc;
    assign app_wdf_data = p0_wr_dout;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = '0;
    assign app_cmd      = APP_CMD_WRITE;
    assign app_addr     = addr_q;
    assign frame_done   = frame_done_q;
    assign busy         = in_burst;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_BURST;
            end
            ST_BURST: begin
                if (cmd_done && dat_done)      state_d = ST_IDLE;
                else if (cmd_done || dat_done) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cmd_done && dat_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            state_q      <= ST_IDLE;
            cmd_cnt      <= '0;
            dat_cnt      <= '0;
            beat_idx     <= '0;
            addr_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= 1'b0;
            if (start) begin
                cmd_cnt <= '0;
                dat_cnt <= '0;
            end else begin
                if (cmd_acc) cmd_cnt <= cmd_cnt + 1'b1;
                if (dat_acc) dat_cnt <= dat_cnt + 1'b1;
            end
            // Address tracks beat_idx incrementally instead of multiplying.
            if (cmd_acc) begin
                if (beat_idx == LAST_BEAT) begin
                    beat_idx     <= '0;
                    addr_q       <= '0;
                    frame_done_q <= 1'b1;
                end else begin
                    beat_idx <= beat_idx + 1'b1;
                    addr_q   <= addr_q + STEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_wr_ddr_burst_ctrl.sv
// Scoreboard bench for wr_ddr_burst_ctrl with BURST_LEN=16, FRAME_BEATS=32, ADDR_STEP=8.
module tb_wr_ddr_burst_ctrl;
    import wr_ddr_burst_ctrl_pkg::*;

    logic                  ui_clk = 1'b0;
    logic                  ui_clk_sync_rst;
    logic                  init_calib_complete;
    logic [CNT_W-1:0]      p0_wr_count;
    logic                  p0_wr_empty;
    logic [APP_DATA_W-1:0] p0_wr_dout;
    logic                  p0_rd_en;
    logic                  app_rdy;
    logic                  app_wdf_rdy;
    logic                  app_en;
    logic [2:0]            app_cmd;
    logic [APP_ADDR_W-1:0] app_addr;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic [APP_DATA_W-1:0] app_wdf_data;
    logic [APP_MASK_W-1:0] app_wdf_mask;
    logic                  frame_done;
    logic                  busy;

    int tests = 0;
    int fails = 0;

    logic [APP_DATA_W-1:0] fifo_q[$];
    logic [APP_DATA_W-1:0] exp_dat[$];
    logic [APP_ADDR_W-1:0] exp_addr[$];
    int                    exp_fd[$];
    int                    cmd_total = 0;
    int                    en_seen = 0;
    int                    seq = 0;
    logic                  pop_pending = 1'b0;
    logic                  prev_stall = 1'b0;
    logic [APP_ADDR_W-1:0] prev_addr = '0;

    wr_ddr_burst_ctrl #(
        .BURST_LEN  (16),
        .FRAME_BEATS(32),
        .ADDR_STEP  (8)
    ) dut (
        .ui_clk             (ui_clk),
        .ui_clk_sync_rst    (ui_clk_sync_rst),
        .init_calib_complete(init_calib_complete),
        .p0_wr_count        (p0_wr_count),
        .p0_wr_empty        (p0_wr_empty),
        .p0_wr_dout         (p0_wr_dout),
        .p0_rd_en           (p0_rd_en),
        .app_rdy            (app_rdy),
        .app_wdf_rdy        (app_wdf_rdy),
        .app_en             (app_en),
        .app_cmd            (app_cmd),
        .app_addr           (app_addr),
        .app_wdf_wren       (app_wdf_wren),
        .app_wdf_end        (app_wdf_end),
        .app_wdf_data       (app_wdf_data),
        .app_wdf_mask       (app_wdf_mask),
        .frame_done         (frame_done),
        .busy               (busy)
    );

    always #5 ui_clk = ~ui_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh_fifo();
        p0_wr_empty = (fifo_q.size() == 0);
        p0_wr_count = (fifo_q.size() > 63) ? 6'd63 : 6'(fifo_q.size());
        p0_wr_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    task automatic push_words(input int n);
        logic [31:0] s;
        for (int i = 0; i < n; i++) begin
            seq++;
            s = 32'(seq);
            fifo_q.push_back({16{s}});
            exp_dat.push_back({16{s}});
        end
        refresh_fifo();
    endtask

    task automatic push_addrs(input int base, input int n);
        for (int i = 0; i < n; i++) exp_addr.push_back(APP_ADDR_W'(base + 8 * i));
    endtask

    task automatic step();
        @(posedge ui_clk);
        #2;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n;
        n = 0;
        while ((busy || exp_addr.size() != 0) && n < bound) begin
            step();
            n++;
        end
        check(name, {62'd0, busy, exp_addr.size() != 0}, 64'd0);
    endtask

    // FIFO model: a beat handshaken during a cycle leaves the FIFO just after the edge.
    always @(negedge ui_clk) pop_pending = p0_rd_en;

    always @(posedge ui_clk) begin
        #1;
        if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_pending = 1'b0;
        refresh_fifo();
    end

    // Monitor: compares every handshake against the scoreboard queues.
    always @(negedge ui_clk) begin
        if (!ui_clk_sync_rst) begin
            if (frame_done) begin
                if (exp_fd.size() == 0) check("frame_done_unexpected", 64'd1, 64'd0);
                else check("frame_done_pos", 64'(cmd_total), 64'(exp_fd.pop_front()));
            end
            if (prev_stall) check("stall_hold", {34'd0, app_en, app_addr}, {34'd0, 1'b1, prev_addr});
            if (app_en || p0_rd_en) en_seen++;
            if (app_en && app_rdy) begin
                cmd_total++;
                if (exp_addr.size() == 0) check("cmd_unexpected", 64'(app_addr), 64'hffff_ffff);
                else check("cmd_addr", 64'(app_addr), 64'(exp_addr.pop_front()));
                check("cmd_code", 64'(app_cmd), 64'(3'b000));
            end
            prev_stall = app_en && !app_rdy;
            prev_addr  = app_addr;
            if (app_wdf_wren && app_wdf_rdy) begin
                if (exp_dat.size() == 0) begin
                    check("wdf_unexpected", 64'd1, 64'd0);
                end else begin
                    logic [APP_DATA_W-1:0] e;
                    e = exp_dat.pop_front();
                    tests++;
                    if (app_wdf_data !== e) begin
                        fails++;
                        $display("FAIL wdf_data: got %h expected %h", app_wdf_data, e);
                    end
                    check("wdf_side", {61'd0, p0_rd_en, app_wdf_end, |app_wdf_mask}, {61'd0, 3'b110});
                end
            end else if (p0_rd_en) begin
                check("rd_en_without_handshake", 64'd1, 64'd0);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int c;
        int n;
        ui_clk_sync_rst     = 1'b1;
        init_calib_complete = 1'b0;
        app_rdy             = 1'b1;
        app_wdf_rdy         = 1'b1;
        refresh_fifo();
        repeat (3) step();
        check("rst_app_en", 64'(app_en), 64'd0);
        check("rst_wdf_wren", 64'(app_wdf_wren), 64'd0);
        check("rst_rd_en", 64'(p0_rd_en), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        ui_clk_sync_rst = 1'b0;

        // Calibration low holds off a full FIFO; then three bursts wrap the 32-beat frame.
        push_words(63);
        en_seen = 0;
        repeat (20) step();
        check("calib_low_no_handshake", 64'(en_seen), 64'd0);
        check("calib_low_idle", 64'(busy), 64'd0);
        push_addrs(0, 32);
        push_addrs(0, 16);
        exp_fd.push_back(32);
        init_calib_complete = 1'b1;
        wait_done("three_bursts_done", 200);
        check("fifo_left_15", 64'(fifo_q.size()), 64'd15);

        // 15 beats stay idle; the 16th starts a burst lasting 17 cycles.
        repeat (5) step();
        check("count15_idle", 64'(busy), 64'd0);
        push_addrs(128, 16);
        exp_fd.push_back(64);
        push_words(1);
        step();
        check("entry_after_count16", 64'(busy), 64'd1);
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        check("burst_busy_cycles", 64'(n), 64'd17);

        // app_rdy low in burst cycles 3..7: data finishes first, channel idles in DRAIN.
        push_addrs(0, 16);
        push_words(20);
        step();
        c = 1;
        while (busy && c < 60) begin
            app_rdy = !(c >= 3 && c <= 7);
            #1;
            if (c >= 17) check("drain_data_idle", 64'(app_wdf_wren), 64'd0);
            if (c == 17) check("drain_cmd_active", 64'(app_en), 64'd1);
            step();
            c++;
        end
        app_rdy = 1'b1;
        check("stall_burst_cycles", 64'(c - 1), 64'd22);
        check("fifo_left_4", 64'(fifo_q.size()), 64'd4);

        // Reset after five beats abandons the burst; the next one restarts at address 0.
        push_addrs(128, 5);
        push_words(12);
        n = 0;
        while (exp_addr.size() != 0 && n < 40) begin
            step();
            n++;
        end
        check("five_beats_sent", 64'(exp_addr.size()), 64'd0);
        ui_clk_sync_rst = 1'b1;
        #1;
        check("rst_no_handshake", {61'd0, app_en, app_wdf_wren, p0_rd_en}, 64'd0);
        step();
        check("rst_mid_outputs", {59'd0, app_en, app_wdf_wren, p0_rd_en, frame_done, busy}, 64'd0);
        check("rst_mid_addr", 64'(app_addr), 64'd0);
        fifo_q.delete();
        exp_dat.delete();
        cmd_total = 0;
        refresh_fifo();
        ui_clk_sync_rst = 1'b0;
        push_addrs(0, 16);
        push_words(16);
        wait_done("post_reset_burst", 60);

        // Calibration drop mid-burst: the burst finishes, no further burst starts.
        push_addrs(128, 16);
        exp_fd.push_back(32);
        push_words(32);
        repeat (3) step();
        init_calib_complete = 1'b0;
        wait_done("calib_drop_burst", 60);
        repeat (10) step();
        check("no_new_burst", 64'(busy), 64'd0);
        check("fifo_left_16", 64'(fifo_q.size()), 64'd16);
        check("exp_dat_left_16", 64'(exp_dat.size()), 64'd16);
        check("frame_done_all_seen", 64'(exp_fd.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
